// File: rtl/hc112_mon_pkg.sv
// Shared types and constants for the hc112 response monitor.
// Covers state encoding, JK codes, pin sample records and the settle-window bound.
package hc112_mon_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FAIL = 2'd2
  } mon_state_e;

  localparam logic [1:0] JK_HOLD = 2'b00;
  localparam logic [1:0] JK_RST  = 2'b01;
  localparam logic [1:0] JK_SET  = 2'b10;
  localparam logic [1:0] JK_TGL  = 2'b11;

  localparam int QUIET_W = 4;

  typedef struct packed {
    logic j;
    logic k;
    logic sdn;
    logic rdn;
    logic cpn;
    logic q;
    logic qn;
  } pin_smp_t;

  typedef struct packed {
    logic sdn;
    logic rdn;
    logic cpn;
  } ctl_smp_t;

  // The quiet counter is 4 bits wide, so the settle window is clamped into 1..15
  function automatic logic [QUIET_W-1:0] settle_chk(input int unsigned s);
    if (s < 1) return QUIET_W'(1);
    if (s > 15) return QUIET_W'(15);
    return QUIET_W'(s);
  endfunction

endpackage

// File: rtl/hc112_monitor_if.sv
// Pin bundle shared by the hc112 stimulus side and the response monitor.
// The master side drives every pin; the monitor only observes.
interface hc112_monitor_if;

  logic J1, K1, SD1N, RD1N, CPN1;
  logic J2, K2, SD2N, RD2N, CPN2;
  logic Q1, Q1N, Q2, Q2N;

  modport master (
    output J1, K1, SD1N, RD1N, CPN1,
    output J2, K2, SD2N, RD2N, CPN2,
    output Q1, Q1N, Q2, Q2N
  );

  modport slave (
    input J1, K1, SD1N, RD1N, CPN1,
    input J2, K2, SD2N, RD2N, CPN2,
    input Q1, Q1N, Q2, Q2N
  );

endinterface

// File: rtl/hc112_ref_ch.sv
// One hc112 channel: input sampling, golden JK model, validity and quiet window.
// Model lags pins by two edges; compares only when valid, quiet and running; never stalls.
module hc112_ref_ch
  import hc112_mon_pkg::*;
#(
  parameter int unsigned SETTLE = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  input  logic j,
  input  logic k,
  input  logic sdn,
  input  logic rdn,
  input  logic cpn,
  input  logic dut_q,
  input  logic dut_qn,
  output logic cmp_en,
  output logic mis
);

  localparam logic [QUIET_W-1:0] QUIET_LD = settle_chk(SETTLE);
  localparam pin_smp_t PIN_IDLE = '{j: 1'b0, k: 1'b0, sdn: 1'b1, rdn: 1'b1,
                                    cpn: 1'b1, q: 1'b0, qn: 1'b1};
  localparam ctl_smp_t CTL_IDLE = '{sdn: 1'b1, rdn: 1'b1, cpn: 1'b1};

  pin_smp_t s1_q, s1_d;
  ctl_smp_t s2_q, s2_d;
  logic mq_q, mq_d, mqn_q, mqn_d, mv_q, mv_d;
  logic [QUIET_W-1:0] quiet_q, quiet_d;
  logic cpn_fall, chg_evt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_q    <= PIN_IDLE;
      s2_q    <= CTL_IDLE;
      mq_q    <= 1'b0;
      mqn_q   <= 1'b1;
      mv_q    <= 1'b0;
      quiet_q <= QUIET_LD;
    end else begin
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      mq_q    <= mq_d;
      mqn_q   <= mqn_d;
      mv_q    <= mv_d;
      quiet_q <= quiet_d;
    end
  end

  always_comb begin
    s1_d = '{j: j, k: k, sdn: sdn, rdn: rdn, cpn: cpn, q: dut_q, qn: dut_qn};
    s2_d = '{sdn: s1_q.sdn, rdn: s1_q.rdn, cpn: s1_q.cpn};
    mq_d = mq_q;
    mqn_d = mqn_q;
    mv_d = mv_q;
    quiet_d = quiet_q;

    cpn_fall = s2_q.cpn & ~s1_q.cpn;
    chg_evt  = cpn_fall | (s1_q.sdn ^ s2_q.sdn) | (s1_q.rdn ^ s2_q.rdn);

    if (!s1_q.sdn && !s1_q.rdn) begin
      mq_d = 1'b1; mqn_d = 1'b1; mv_d = 1'b1;
    end else if (!s1_q.sdn) begin
      mq_d = 1'b1; mqn_d = 1'b0; mv_d = 1'b1;
    end else if (!s1_q.rdn) begin
      mq_d = 1'b0; mqn_d = 1'b1; mv_d = 1'b1;
    end else if (cpn_fall) begin
      case ({s1_q.j, s1_q.k})
        JK_RST:  begin mq_d = 1'b0; mqn_d = 1'b1; mv_d = 1'b1; end
        JK_SET:  begin mq_d = 1'b1; mqn_d = 1'b0; mv_d = 1'b1; end
        JK_TGL:  begin mq_d = ~mq_q; mqn_d = mq_q; end
        default: ;
      endcase
    end

    if (chg_evt) quiet_d = QUIET_LD;
    else if (quiet_q != '0) quiet_d = quiet_q - 1'b1;

    // The model has not absorbed an event seen this cycle yet, so that cycle is never compared
    cmp_en = run & mv_q & (quiet_q == '0) & ~chg_evt;
    mis    = cmp_en & ({s1_q.q, s1_q.qn} != {mq_q, mqn_q});
  end

endmodule

// File: rtl/hc112_monitor.sv
// hc112 response checker: two reference channels, run/fail control, saturating counters.
// Results trail the pins by SETTLE+2 edges or more; purely observational, no backpressure.
module hc112_monitor
  import hc112_mon_pkg::*;
#(
  parameter int unsigned SETTLE      = 2,
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned HALT_ON_ERR = 0
) (
  input  logic             CP,
  input  logic             RDN,
  input  logic             EN,
  input  logic             CLR,
  hc112_monitor_if.slave   pins,
  output logic             ERR1,
  output logic             ERR2,
  output logic [CNT_W-1:0] MIS1,
  output logic [CNT_W-1:0] MIS2,
  output logic [CNT_W-1:0] CHK,
  output logic [1:0]       FIRST_CH,
  output logic [CNT_W-1:0] FIRST_IDX,
  output logic [1:0]       STATE
);

  mon_state_e state_q, state_d;
  logic [CNT_W-1:0] chk_q, chk_d, mis1_q, mis1_d, mis2_q, mis2_d, first_idx_q, first_idx_d;
  logic err1_q, err1_d, err2_q, err2_d;
  logic [1:0] first_ch_q, first_ch_d;
  logic run, cmp1, cmp2, mis1, mis2, any_mis;
  logic [1:0] cmp_n;

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] v, input logic [1:0] n);
    logic [CNT_W:0] s;
    s = {1'b0, v} + {{(CNT_W-1){1'b0}}, n};
    return s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
  endfunction

  assign run = (state_q == ST_RUN);

  hc112_ref_ch #(.SETTLE(SETTLE)) u_ch1 (
    .clk(CP), .rst_n(RDN), .run(run),
    .j(pins.J1), .k(pins.K1), .sdn(pins.SD1N), .rdn(pins.RD1N), .cpn(pins.CPN1),
    .dut_q(pins.Q1), .dut_qn(pins.Q1N), .cmp_en(cmp1), .mis(mis1)
  );

  hc112_ref_ch #(.SETTLE(SETTLE)) u_ch2 (
    .clk(CP), .rst_n(RDN), .run(run),
    .j(pins.J2), .k(pins.K2), .sdn(pins.SD2N), .rdn(pins.RD2N), .cpn(pins.CPN2),
    .dut_q(pins.Q2), .dut_qn(pins.Q2N), .cmp_en(cmp2), .mis(mis2)
  );

  always_ff @(posedge CP) begin
    if (!RDN) begin
      state_q     <= ST_IDLE;
      chk_q       <= '0;
      mis1_q      <= '0;
      mis2_q      <= '0;
      err1_q      <= 1'b0;
      err2_q      <= 1'b0;
      first_ch_q  <= 2'd0;
      first_idx_q <= '0;
    end else begin
      state_q     <= state_d;
      chk_q       <= chk_d;
      mis1_q      <= mis1_d;
      mis2_q      <= mis2_d;
      err1_q      <= err1_d;
      err2_q      <= err2_d;
      first_ch_q  <= first_ch_d;
      first_idx_q <= first_idx_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    chk_d       = chk_q;
    mis1_d      = mis1_q;
    mis2_d      = mis2_q;
    err1_d      = err1_q;
    err2_d      = err2_q;
    first_ch_d  = first_ch_q;
    first_idx_d = first_idx_q;
    any_mis     = mis1 | mis2;
    cmp_n       = {1'b0, cmp1} + {1'b0, cmp2};

    case (state_q)
      ST_IDLE: if (EN) state_d = ST_RUN;
      ST_RUN: begin
        // A clear in the same cycle wins over a halting mismatch
        if ((HALT_ON_ERR != 0) && any_mis && !CLR) state_d = ST_FAIL;
        else if (!EN) state_d = ST_IDLE;
      end
      ST_FAIL: if (CLR) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    if (CLR) begin
      chk_d       = '0;
      mis1_d      = '0;
      mis2_d      = '0;
      err1_d      = 1'b0;
      err2_d      = 1'b0;
      first_ch_d  = 2'd0;
      first_idx_d = '0;
    end else begin
      if ((first_ch_q == 2'd0) && any_mis) begin
        first_ch_d  = {mis2, mis1};
        first_idx_d = chk_q;
      end
      chk_d  = sat_add(chk_q, cmp_n);
      mis1_d = sat_add(mis1_q, {1'b0, mis1});
      mis2_d = sat_add(mis2_q, {1'b0, mis2});
      err1_d = err1_q | mis1;
      err2_d = err2_q | mis2;
    end
  end

  assign ERR1      = err1_q;
  assign ERR2      = err2_q;
  assign MIS1      = mis1_q;
  assign MIS2      = mis2_q;
  assign CHK       = chk_q;
  assign FIRST_CH  = first_ch_q;
  assign FIRST_IDX = first_idx_q;
  assign STATE     = state_q;

endmodule
